// File: rtl/div_pkg.sv
// Shared types, default sizes and the round-robin pick helper for the divider scheduler.
package div_pkg;

    localparam int unsigned DIV_WIDTH   = 32;
    localparam int unsigned DIV_N_REQ   = 4;
    localparam int unsigned DIV_MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP
    } div_state_t;

    // One-hot pick of the first valid bit after 'last', wrapping. Bits above the
    // real requester count are zero, so wrapping modulo 8 gives the same order
    // as wrapping modulo N_REQ.
    function automatic logic [DIV_MAX_REQ-1:0] rr_pick(input logic [DIV_MAX_REQ-1:0] valid,
                                                       input logic [2:0]             last);
        logic [DIV_MAX_REQ-1:0] grant;
        logic [2:0]             idx;
        logic                   found;
        grant = '0;
        found = 1'b0;
        for (int i = 1; i <= int'(DIV_MAX_REQ); i++) begin
            idx = last + 3'(i);
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per clock, MSB first.
module div_iter
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             run_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   r_nx;
    logic             ge;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] r_d;

    // One restoring step; the widened partial remainder cannot overflow for large divisors.
    always_comb begin
        r_sh = {r_q, a_q[WIDTH-1]};
        ge   = (r_sh >= {1'b0, b_q});
        r_nx = ge ? (r_sh - {1'b0, b_q}) : r_sh;
        r_d  = WIDTH'(r_nx);
        q_d  = (q_q << 1) | WIDTH'(ge);
    end

    // On the last step the combinational results are the final quotient/remainder.
    assign done = run_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign q    = q_d;
    assign r    = r_d;

    // Step counter and shift registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            q_q   <= '0;
        end else if (start) begin
            run_q <= 1'b1;
            cnt_q <= '0;
            a_q   <= a;
            b_q   <= b;
            r_q   <= '0;
            q_q   <= '0;
        end else if (run_q) begin
            a_q   <= a_q << 1;
            r_q   <= r_d;
            q_q   <= q_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/div_scheduler.sv
// Round-robin front end sharing one iterative divider among several requesters.
module div_scheduler
    import div_pkg::*;
#(
    parameter int unsigned N_REQ = DIV_N_REQ,
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned ID_W  = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [WIDTH-1:0]       resp_q,
    output logic [WIDTH-1:0]       resp_r,
    output logic                   resp_dbz,
    output logic                   busy
);

    div_state_t       state_q;
    logic [ID_W-1:0]  last_grant_q;
    logic [ID_W-1:0]  id_q;
    logic             dbz_q;

    logic [N_REQ-1:0] pick;
    logic [ID_W-1:0]  id_c;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             hs;
    logic             done;
    logic [WIDTH-1:0] iter_q;
    logic [WIDTH-1:0] iter_r;

    // Arbiter: the grant is offered only in IDLE and never while reset is held.
    assign pick      = N_REQ'(rr_pick(DIV_MAX_REQ'(req_valid), 3'(last_grant_q)));
    assign req_ready = (state_q == IDLE && reset_n) ? pick : '0;
    assign hs        = |(req_valid & req_ready);

    // Operand and id mux driven by the one-hot grant.
    always_comb begin
        id_c  = '0;
        a_sel = '0;
        b_sel = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (req_ready[k]) begin
                id_c  = ID_W'(k);
                a_sel = req_a[k*WIDTH +: WIDTH];
                b_sel = req_b[k*WIDTH +: WIDTH];
            end
        end
    end

    div_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (hs),
        .a       (a_sel),
        .b       (b_sel),
        .done    (done),
        .q       (iter_q),
        .r       (iter_r)
    );

    // Control FSM with registered response port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(N_REQ - 1);
            id_q         <= '0;
            dbz_q        <= 1'b0;
            resp_valid   <= 1'b0;
            resp_id      <= '0;
            resp_q       <= '0;
            resp_r       <= '0;
            resp_dbz     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        last_grant_q <= id_c;
                        id_q         <= id_c;
                        dbz_q        <= (b_sel == '0);
                        busy         <= 1'b1;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    if (done) begin
                        resp_valid <= 1'b1;
                        resp_id    <= id_q;
                        resp_q     <= iter_q;
                        resp_r     <= iter_r;
                        resp_dbz   <= dbz_q;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_scheduler.sv
// Directed scoreboard bench for div_scheduler.
module tb_div_scheduler;

    localparam int N = 4;
    localparam int W = 32;

    logic           clock = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           resp_valid;
    logic           resp_ready;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_q;
    logic [W-1:0]   resp_r;
    logic           resp_dbz;
    logic           busy;

    typedef struct packed {
        logic [1:0]   id;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    exp_t last_e;
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    div_scheduler #(.N_REQ(N), .WIDTH(W), .ID_W(2)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_q     (resp_q),
        .resp_r     (resp_r),
        .resp_dbz   (resp_dbz),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        fails++;
        $error("FAIL %s: bound expired", tag);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic exp_t model(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.id = 2'(id);
        if (b == 0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[k*W +: W] = a;
        req_b[k*W +: W] = b;
    endtask

    task automatic check_zero_outs(input string tag);
        chk({tag, "_rdy"},   64'(req_ready), 64'(0));
        chk({tag, "_valid"}, 64'(resp_valid), 64'(0));
        chk({tag, "_id"},    64'(resp_id), 64'(0));
        chk({tag, "_q"},     64'(resp_q), 64'(0));
        chk({tag, "_r"},     64'(resp_r), 64'(0));
        chk({tag, "_dbz"},   64'(resp_dbz), 64'(0));
        chk({tag, "_busy"},  64'(busy), 64'(0));
    endtask

    // Waits for a grant; pushes the expected result for the winner.
    task automatic wait_grant(output int id, output int gcyc);
        int n = 0;
        id   = -1;
        gcyc = cyc;
        while (req_ready == '0 && n < 100) begin
            tick();
            n++;
        end
        if (req_ready == '0) begin
            timeout("grant_timeout");
        end else begin
            chk("grant_onehot", 64'($onehot(req_ready)), 64'(1));
            for (int k = 0; k < N; k++) if (req_ready[k]) id = k;
            gcyc = cyc;
            sb.push_back(model(id, req_a[id*W +: W], req_b[id*W +: W]));
        end
    endtask

    // Waits for the response, checks latency and pops/compares the scoreboard.
    task automatic wait_resp(input int gcyc);
        int n = 0;
        while (!resp_valid && n < 60) begin
            chk("rdy_zero_busy", 64'(req_ready), 64'(0));
            tick();
            n++;
        end
        if (!resp_valid) begin
            timeout("resp_timeout");
        end else if (sb.size() == 0) begin
            timeout("resp_unexpected");
        end else begin
            last_e = sb.pop_front();
            chk("latency", 64'(cyc - gcyc), 64'(33));
            chk("resp_id",  64'(resp_id),  64'(last_e.id));
            chk("resp_q",   64'(resp_q),   64'(last_e.q));
            chk("resp_r",   64'(resp_r),   64'(last_e.r));
            chk("resp_dbz", 64'(resp_dbz), 64'(last_e.dbz));
            chk("resp_busy", 64'(busy), 64'(1));
        end
    endtask

    task automatic run_one(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        int id, g;
        set_op(k, a, b);
        req_valid[k] = 1'b1;
        #1;
        wait_grant(id, g);
        chk("grant_id", 64'(id), 64'(k));
        chk("grant_vec", 64'(req_ready), 64'(1 << k));
        tick();
        req_valid[k] = 1'b0;
        wait_resp(g);
        tick();
        chk("resp_drop", 64'(resp_valid), 64'(0));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        check_zero_outs("reset");
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int id, g, prev, a0;
        reset_n    = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        #12;
        check_zero_outs("por");
        tick();
        reset_n = 1'b1;
        tick();

        // Single requests and edge operands.
        run_one(2, 32'd100, 32'd7);
        run_one(0, 32'd5, 32'd0);
        run_one(1, 32'hFFFF_FFFF, 32'd1);
        run_one(3, 32'd3, 32'd7);
        run_one(2, 32'hFFFF_FFFF, 32'h8000_0001);

        // Continuous contention from reset: order 0,1,2,3,0 spaced 34 cycles.
        do_reset();
        for (int k = 0; k < N; k++) set_op(k, 32'(1000 + k * 37), 32'(k + 3));
        req_valid = '1;
        #1;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_grant(id, g);
            chk("rr_order", 64'(id), 64'(i % N));
            if (i > 0) chk("rr_spacing", 64'(g - prev), 64'(34));
            prev = g;
            tick();
            wait_resp(g);
            if (i == 4) req_valid = '0;
        end
        tick();

        // Backpressure: response held 10 cycles, then handshake and next grant.
        resp_ready = 1'b0;
        set_op(1, 32'd999, 32'd13);
        req_valid[1] = 1'b1;
        #1;
        wait_grant(id, g);
        tick();
        req_valid[1] = 1'b0;
        wait_resp(g);
        set_op(3, 32'd77, 32'd5);
        req_valid[3] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 64'(resp_valid), 64'(1));
            chk("bp_q",     64'(resp_q), 64'(last_e.q));
            chk("bp_r",     64'(resp_r), 64'(last_e.r));
            chk("bp_id",    64'(resp_id), 64'(last_e.id));
            chk("bp_rdy",   64'(req_ready), 64'(0));
            chk("bp_busy",  64'(busy), 64'(1));
            tick();
        end
        a0 = cyc;
        resp_ready = 1'b1;
        #1;
        chk("bp_hold_last", 64'(resp_valid), 64'(1));
        tick();
        chk("bp_released", 64'(resp_valid), 64'(0));
        wait_grant(id, g);
        chk("bp_next_grant_cyc", 64'(g - a0), 64'(1));
        chk("bp_next_grant_id", 64'(id), 64'(3));
        tick();
        req_valid[3] = 1'b0;
        wait_resp(g);
        tick();

        // Reset during RUN cycle 15: abandoned, then requester 0 wins a tie with 3.
        set_op(1, 32'd1234, 32'd11);
        req_valid[1] = 1'b1;
        #1;
        wait_grant(id, g);
        tick();
        req_valid[1] = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        reset_n = 1'b0;
        #1;
        check_zero_outs("midrun_rst");
        sb.delete();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            chk("no_resp_after_rst", 64'(resp_valid), 64'(0));
            tick();
        end
        set_op(0, 32'd50, 32'd6);
        set_op(3, 32'd81, 32'd9);
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        #1;
        wait_grant(id, g);
        chk("tie_winner", 64'(id), 64'(0));
        tick();
        req_valid[0] = 1'b0;
        wait_resp(g);
        wait_grant(id, g);
        chk("tie_second", 64'(id), 64'(3));
        tick();
        req_valid[3] = 1'b0;
        wait_resp(g);
        tick();
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/div_scheduler.md
# div_scheduler

Shares one iterative restoring 32-bit divider among `N_REQ` requesters. Each requester has its own valid/ready request port, and a round-robin arbiter decides who is served next. The block sequences the divider through one bit per clock and returns a tagged quotient/remainder on a single response port with backpressure. It sits between client blocks needing occasional division and the divider datapath, and replaces free-running `start` pulsing with a proper handshake.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `WIDTH`, 32: operand width; iteration count equals `WIDTH`.
- `ID_W`, 2: `resp_id` width, equal to clog2(`N_REQ`).

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `N_REQ`  per-requester request valid.
- `req_ready`  out  `N_REQ`  per-requester accept; at most one bit high (one-hot).
- `req_a`  in  `N_REQ*WIDTH`  dividends; requester k occupies bits [k*WIDTH +: WIDTH].
- `req_b`  in  `N_REQ*WIDTH`  divisors; same packing as `req_a`.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts result.
- `resp_id`  out  `ID_W`  index of the served requester.
- `resp_q`  out  `WIDTH`  quotient.
- `resp_r`  out  `WIDTH`  remainder.
- `resp_dbz`  out  1  divisor was zero.
- `busy`  out  1  high in RUN and RESP.

## Operation
- FSM states:
  - IDLE: waits for any `req_valid`.
  - RUN: divider iterating.
  - RESP: result held on the response port.
- IDLE:
  - The arbiter is combinational. It searches from `last_grant+1` modulo `N_REQ` and picks the first requester with `req_valid` high.
  - `req_ready` is asserted for that winner only, in the same cycle. The handshake (valid & ready) latches a, b and id, sets `last_grant`, starts the divider and moves to RUN.
  - `req_ready` is all-zero outside IDLE.
- RUN:
  - One restoring step per cycle, MSB first: r = (r<<1) | a[i]. If r >= b, then r -= b and q[i] = 1; otherwise q[i] = 0.
  - The partial remainder is `WIDTH+1` bits wide internally, so no overflow when b > 2^(WIDTH-1).
  - After `WIDTH` steps, q, r and dbz are registered and the FSM moves to RESP.
- RESP:
  - `resp_valid` = 1 and all response fields are stable.
  - On `resp_ready` the FSM returns to IDLE.
  - No new grant is issued in the same cycle as the response handshake.
- Divide by zero: b == 0 yields q = all ones and r = a, which is the natural restoring result. `resp_dbz` = 1. Latency is unchanged.
- Requests are not queued. A requester holds `req_valid` (and its operands stable) until it sees `req_ready`. Dropping valid before grant is legal and simply withdraws the request.

## Timing
- Reset values:
  - `req_ready` = 0, `resp_valid` = 0, `resp_id` = 0, `resp_q` = 0, `resp_r` = 0, `resp_dbz` = 0, `busy` = 0.
  - State = IDLE, `last_grant` = `N_REQ`-1, so requester 0 has priority first.
- Latency: request handshake in cycle 0. RUN occupies cycles 1..`WIDTH`. `resp_valid` first high in cycle `WIDTH`+1 (33).
- Throughput: with `resp_ready` held high, one operation per `WIDTH`+2 cycles (34). The next grant comes in the cycle after the response handshake.
- `resp_valid` with `resp_ready` low: hold for any number of cycles with all fields stable. `req_ready` stays 0 throughout.
- Simultaneous requests: exactly one grant per IDLE cycle. Over repeated contention each active requester is served once per `N_REQ` grants.
- Reset asserted mid-RUN or mid-RESP: the operation is abandoned and no response is issued. Outputs go to reset values asynchronously. After reset deassertion the first grant starts from requester 0.
- `req_*` inputs are sampled only in the handshake cycle. Changes during RUN have no effect.

## Structure
- Package `div_pkg`:
  - state enum `div_state_t` {IDLE, RUN, RESP};
  - default constants `DIV_WIDTH` = 32 and `DIV_N_REQ` = 4;
  - round-robin pick function `rr_pick(valid, last)`, which returns one-hot.
- Sub-module `div_iter`: the iterative datapath.
  - Inputs: `clock`, `reset_n`, `start`, `a`, `b`.
  - Outputs: `done` (1-cycle pulse on the last step), `q`, `r`.
  - Contains the step counter and partial-remainder register.
- `div_scheduler` holds the FSM, arbiter, `last_grant` and the response registers.

## Test plan
- Single request, requester 2, a=100, b=7, `resp_ready`=1 -> `req_ready[2]` high in the request cycle. 33 cycles later `resp_valid` goes high with q=14, r=2, id=2, dbz=0.
- Divide by zero, a=5, b=0 -> q=0xFFFFFFFF, r=5, dbz=1, latency 33.
- Edge operands:
  - a=0xFFFFFFFF, b=1 -> q=0xFFFFFFFF, r=0;
  - a=3, b=7 -> q=0, r=3;
  - a=0xFFFFFFFF, b=0x80000001 -> q=1, r=0x7FFFFFFE.
- All four requesters valid continuously after reset -> grant order 0,1,2,3,0, each 34 cycles apart. `req_ready` is always one-hot or zero.
- Backpressure: `resp_ready` low for 10 cycles after `resp_valid` -> response fields stable, `req_ready` = 0, `busy` = 1. Handshake on cycle 11, then a grant on the following cycle.
- `reset_n` pulsed low in RUN cycle 15 -> outputs zero immediately and no response appears. A new request after reset completes correctly, and requester 0 wins a tie with requester 3.
